// File: rtl/exe_fwd_tracker.sv
// In-flight result tracker for EXE and later stages: forwarding lookup,
// load-use/VDOT-use hazard detection and register-file writeback from the last slot.
module exe_fwd_tracker #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 3,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_STAGE = 1,
  parameter int VDOT_STAGE = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    valid_exe,
  input  logic [XLEN-1:0]         pc_exe,
  input  logic [XLEN-1:0]         inst_exe,
  input  logic [4:0]              rd_exe,
  input  logic                    reg_write_exe,
  input  logic [1:0]              op_type_exe,
  input  logic [XLEN-1:0]         alu_out,
  input  logic [XLEN-1:0]         mem_data,
  input  logic [XLEN-1:0]         vdot_data,
  input  logic [5*NUM_SRC-1:0]    rs_addr,
  output logic [NUM_SRC-1:0]      fwd_hit,
  output logic [XLEN*NUM_SRC-1:0] fwd_data,
  output logic                    hazard_stall,
  output logic                    wb_valid,
  output logic [4:0]              wb_rd,
  output logic [XLEN-1:0]         wb_data,
  output logic [XLEN-1:0]         wb_pc
);

  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_VDOT = 2'b10;
  localparam logic [1:0] OP_NONE = 2'b11;

  // Registered slots 1..DEPTH-1
  logic            r_valid     [1:DEPTH-1];
  logic [XLEN-1:0] r_pc        [1:DEPTH-1];
  logic [XLEN-1:0] r_inst      [1:DEPTH-1];
  logic [4:0]      r_rd        [1:DEPTH-1];
  logic            r_reg_write [1:DEPTH-1];
  logic [1:0]      r_op        [1:DEPTH-1];
  logic [XLEN-1:0] r_data      [1:DEPTH-1];

  // Unified view of all slots, slot 0 taken straight from the EXE inputs
  logic            s_valid     [DEPTH];
  logic [XLEN-1:0] s_pc        [DEPTH];
  logic [XLEN-1:0] s_inst      [DEPTH];
  logic [4:0]      s_rd        [DEPTH];
  logic            s_reg_write [DEPTH];
  logic [1:0]      s_op        [DEPTH];
  logic [XLEN-1:0] s_data      [DEPTH];
  logic [XLEN-1:0] s_eff       [DEPTH];
  logic            s_ready     [DEPTH];
  logic [NUM_SRC-1:0] haz;

  always_comb begin
    s_valid[0]     = valid_exe;
    s_pc[0]        = pc_exe;
    s_inst[0]      = inst_exe;
    s_rd[0]        = rd_exe;
    s_reg_write[0] = reg_write_exe;
    s_op[0]        = op_type_exe;
    s_data[0]      = (op_type_exe == OP_ALU) ? alu_out : '0;
    for (int k = 1; k < DEPTH; k++) begin
      s_valid[k]     = r_valid[k];
      s_pc[k]        = r_pc[k];
      s_inst[k]      = r_inst[k];
      s_rd[k]        = r_rd[k];
      s_reg_write[k] = r_reg_write[k];
      s_op[k]        = r_op[k];
      s_data[k]      = r_data[k];
    end
  end

  // Late results are spliced in at the slot where they first become valid
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      s_eff[k] = s_data[k];
      if (k == LOAD_STAGE && s_op[k] == OP_LOAD)
        s_eff[k] = mem_data;
      else if (k == VDOT_STAGE && s_op[k] == OP_VDOT)
        s_eff[k] = vdot_data;
      case (s_op[k])
        OP_ALU:  s_ready[k] = 1'b1;
        OP_LOAD: s_ready[k] = (k >= LOAD_STAGE);
        OP_VDOT: s_ready[k] = (k >= VDOT_STAGE);
        default: s_ready[k] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k < DEPTH; k++) begin
        r_valid[k]     <= 1'b0;
        r_pc[k]        <= '0;
        r_inst[k]      <= '0;
        r_rd[k]        <= '0;
        r_reg_write[k] <= 1'b0;
        r_op[k]        <= '0;
        r_data[k]      <= '0;
      end
    end else if (!stall) begin
      for (int k = 1; k < DEPTH; k++) begin
        r_valid[k]     <= (k == 1) ? (valid_exe & ~flush) : s_valid[k-1];
        r_pc[k]        <= s_pc[k-1];
        r_inst[k]      <= s_inst[k-1];
        r_rd[k]        <= s_rd[k-1];
        r_reg_write[k] <= s_reg_write[k-1];
        r_op[k]        <= s_op[k-1];
        r_data[k]      <= s_eff[k-1];
      end
    end
  end

  // Scan oldest to youngest so the youngest match overwrites; a not-ready
  // youngest match hides any older producer of the same register.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    haz      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (s_valid[k] && s_reg_write[k] && s_rd[k] == rs_addr[5*i +: 5] &&
            s_rd[k] != 5'd0 && s_op[k] != OP_NONE) begin
          fwd_hit[i]               = s_ready[k];
          fwd_data[i*XLEN +: XLEN] = s_ready[k] ? s_eff[k] : '0;
          haz[i]                   = ~s_ready[k];
        end
      end
    end
  end

  assign hazard_stall = |haz;

  assign wb_valid = s_valid[DEPTH-1] & s_reg_write[DEPTH-1] & (s_op[DEPTH-1] != OP_NONE);
  assign wb_rd    = s_rd[DEPTH-1];
  assign wb_data  = s_eff[DEPTH-1];
  assign wb_pc    = s_pc[DEPTH-1];

  // The instruction word travels with its slot but nothing consumes it past the last slot
  logic unused_inst;
  assign unused_inst = ^s_inst[DEPTH-1];

endmodule

// File: tb/tb_exe_fwd_tracker.sv
// Directed bench for exe_fwd_tracker (DEPTH=3, LOAD_STAGE=1, VDOT_STAGE=2),
// with a writeback scoreboard fed from the issue stream.
module tb_exe_fwd_tracker;
  localparam int XLEN    = 32;
  localparam int DEPTH   = 3;
  localparam int NUM_SRC = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    stall;
  logic                    flush;
  logic                    valid_exe;
  logic [XLEN-1:0]         pc_exe;
  logic [XLEN-1:0]         inst_exe;
  logic [4:0]              rd_exe;
  logic                    reg_write_exe;
  logic [1:0]              op_type_exe;
  logic [XLEN-1:0]         alu_out;
  logic [XLEN-1:0]         mem_data;
  logic [XLEN-1:0]         vdot_data;
  logic [5*NUM_SRC-1:0]    rs_addr;
  logic [NUM_SRC-1:0]      fwd_hit;
  logic [XLEN*NUM_SRC-1:0] fwd_data;
  logic                    hazard_stall;
  logic                    wb_valid;
  logic [4:0]              wb_rd;
  logic [XLEN-1:0]         wb_data;
  logic [XLEN-1:0]         wb_pc;

  exe_fwd_tracker #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NUM_SRC(NUM_SRC), .LOAD_STAGE(1), .VDOT_STAGE(2)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .valid_exe(valid_exe), .pc_exe(pc_exe), .inst_exe(inst_exe), .rd_exe(rd_exe),
    .reg_write_exe(reg_write_exe), .op_type_exe(op_type_exe), .alu_out(alu_out),
    .mem_data(mem_data), .vdot_data(vdot_data), .rs_addr(rs_addr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .hazard_stall(hazard_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [36:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] rd,
                       input logic [31:0] d, input logic [31:0] pc);
    valid_exe     = 1'b1;
    reg_write_exe = 1'b1;
    op_type_exe   = op;
    rd_exe        = rd;
    alu_out       = d;
    pc_exe        = pc;
    inst_exe      = 32'h0000_0013 ^ pc;
  endtask

  task automatic idle();
    valid_exe     = 1'b0;
    reg_write_exe = 1'b0;
    op_type_exe   = 2'b11;
    rd_exe        = 5'd0;
    alu_out       = '0;
    pc_exe        = '0;
    inst_exe      = '0;
  endtask

  task automatic set_rs(input logic [4:0] rs1, input logic [4:0] rs0);
    rs_addr = {rs1, rs0};
  endtask

  // scoreboard: each writeback presented while not stalled retires the oldest expected entry
  initial begin
    logic [36:0] e;
    logic        have;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && wb_valid === 1'b1 && stall === 1'b0) begin
        have = (exp_q.size() != 0);
        check("wb_has_expected", {31'b0, have}, 32'd1);
        if (have) begin
          e = exp_q.pop_front();
          check("wb_rd_sb", {27'b0, wb_rd}, {27'b0, e[36:32]});
          check("wb_data_sb", wb_data, e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    mem_data = '0; vdot_data = '0;
    idle();
    set_rs(5'd0, 5'd0);

    // reset holds the writeback port at zero even with a live EXE instruction
    issue(2'b00, 5'd5, 32'h11, 32'h100);
    sample();
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_pc", wb_pc, 32'd0);
    tick();
    idle();
    sample();
    check("rst_wb_valid_edge", {31'b0, wb_valid}, 32'd0);
    rst = 1'b1;

    // single ALU result walks to writeback
    tick();
    issue(2'b00, 5'd5, 32'h11, 32'h100);
    exp_q.push_back({5'd5, 32'h11});
    set_rs(5'd0, 5'd5);
    sample();
    check("alu_s0_hit", {31'b0, fwd_hit[0]}, 32'd1);
    check("alu_s0_data", fwd_data[31:0], 32'h11);
    tick();
    idle();
    sample();
    check("alu_s1_data", fwd_data[31:0], 32'h11);
    check("alu_s1_wb_valid", {31'b0, wb_valid}, 32'd0);
    tick();
    sample();
    check("alu_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("alu_wb_rd", {27'b0, wb_rd}, 32'd5);
    check("alu_wb_data", wb_data, 32'h11);
    check("alu_wb_pc", wb_pc, 32'h100);
    tick();
    sample();
    check("alu_wb_pulse_end", {31'b0, wb_valid}, 32'd0);

    // back-to-back writers of x3: youngest wins
    tick();
    issue(2'b00, 5'd3, 32'hA, 32'h200);
    exp_q.push_back({5'd3, 32'hA});
    set_rs(5'd0, 5'd3);
    sample();
    check("b2b_first", fwd_data[31:0], 32'hA);
    tick();
    issue(2'b00, 5'd3, 32'hB, 32'h204);
    exp_q.push_back({5'd3, 32'hB});
    sample();
    check("b2b_youngest_s0", fwd_data[31:0], 32'hB);
    tick();
    idle();
    sample();
    check("b2b_youngest_s1", fwd_data[31:0], 32'hB);
    tick();
    sample();
    check("b2b_s2_hit", {31'b0, fwd_hit[0]}, 32'd1);
    check("b2b_s2_data", fwd_data[31:0], 32'hB);
    tick();
    sample();
    check("b2b_drained", {31'b0, fwd_hit[0]}, 32'd0);

    // load-use on source 1
    tick();
    issue(2'b01, 5'd7, 32'h999, 32'h300);
    exp_q.push_back({5'd7, 32'hDEAD});
    set_rs(5'd7, 5'd0);
    sample();
    check("ld_s0_hazard", {31'b0, hazard_stall}, 32'd1);
    check("ld_s0_hit", {30'b0, fwd_hit}, 32'd0);
    check("ld_s0_data", fwd_data[63:32], 32'd0);
    tick();
    idle();
    mem_data = 32'hDEAD;
    sample();
    check("ld_s1_hit", {31'b0, fwd_hit[1]}, 32'd1);
    check("ld_s1_data", fwd_data[63:32], 32'hDEAD);
    check("ld_s1_hazard", {31'b0, hazard_stall}, 32'd0);
    tick();
    mem_data = 32'h0;
    sample();
    check("ld_s2_captured", fwd_data[63:32], 32'hDEAD);
    check("ld_wb_valid", {31'b0, wb_valid}, 32'd1);

    // VDOT needs two cycles before its result is usable
    tick();
    issue(2'b10, 5'd9, 32'h777, 32'h400);
    exp_q.push_back({5'd9, 32'h1234});
    set_rs(5'd0, 5'd9);
    sample();
    check("vd_s0_hazard", {31'b0, hazard_stall}, 32'd1);
    check("vd_s0_hit", {31'b0, fwd_hit[0]}, 32'd0);
    tick();
    idle();
    sample();
    check("vd_s1_hazard", {31'b0, hazard_stall}, 32'd1);
    tick();
    vdot_data = 32'h1234;
    sample();
    check("vd_s2_hit", {31'b0, fwd_hit[0]}, 32'd1);
    check("vd_s2_data", fwd_data[31:0], 32'h1234);
    check("vd_s2_hazard", {31'b0, hazard_stall}, 32'd0);
    check("vd_wb_data", wb_data, 32'h1234);
    tick();
    vdot_data = 32'h0;
    sample();
    check("vd_wb_end", {31'b0, wb_valid}, 32'd0);

    // x0 never forwards
    tick();
    issue(2'b00, 5'd0, 32'h55, 32'h500);
    exp_q.push_back({5'd0, 32'h55});
    set_rs(5'd0, 5'd0);
    sample();
    check("x0_hit", {30'b0, fwd_hit}, 32'd0);
    check("x0_hazard", {31'b0, hazard_stall}, 32'd0);
    tick();
    idle();
    tick();
    tick();

    // stall holds everything; flush kills the EXE instruction
    tick();
    issue(2'b00, 5'd6, 32'h66, 32'h600);
    exp_q.push_back({5'd6, 32'h66});
    tick();
    issue(2'b00, 5'd8, 32'h88, 32'h604);
    exp_q.push_back({5'd8, 32'h88});
    tick();
    idle();
    stall = 1'b1;
    set_rs(5'd0, 5'd8);
    for (int c = 0; c < 3; c++) begin
      sample();
      check("stl_wb_rd", {27'b0, wb_rd}, 32'd6);
      check("stl_wb_data", wb_data, 32'h66);
      check("stl_s1_data", fwd_data[31:0], 32'h88);
      tick();
    end
    sample();
    check("stl_wb_pc", wb_pc, 32'h600);
    tick();
    stall = 1'b0;
    flush = 1'b1;
    issue(2'b00, 5'd4, 32'h44, 32'h608);
    set_rs(5'd0, 5'd4);
    sample();
    check("fl_s0_hit", {31'b0, fwd_hit[0]}, 32'd1);
    tick();
    flush = 1'b0;
    idle();
    sample();
    check("fl_s1_nohit", {31'b0, fwd_hit[0]}, 32'd0);
    check("fl_wb_rd", {27'b0, wb_rd}, 32'd8);
    tick();
    sample();
    check("fl_no_retire", {31'b0, wb_valid}, 32'd0);

    // asynchronous reset with two entries in flight
    tick();
    issue(2'b00, 5'd10, 32'hAA, 32'h700);
    exp_q.push_back({5'd10, 32'hAA});
    tick();
    issue(2'b00, 5'd11, 32'hBB, 32'h704);
    tick();
    idle();
    set_rs(5'd0, 5'd11);
    sample();
    check("ar_pre_wb_rd", {27'b0, wb_rd}, 32'd10);
    check("ar_pre_hit", {31'b0, fwd_hit[0]}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("ar_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("ar_wb_data", wb_data, 32'd0);
    check("ar_hit", {31'b0, fwd_hit[0]}, 32'd0);
    tick();
    rst = 1'b1;
    sample();
    check("ar_after_wb", {31'b0, wb_valid}, 32'd0);
    check("ar_after_hit", {31'b0, fwd_hit[0]}, 32'd0);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
